// File: rtl/snn_pkg.sv
// snn_pkg: shared RX state encoding and image/baud constants for the SNN image link
package snn_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, UNPACK} rx_state_t;
  localparam int IMG_BITS = 784;
  localparam int DEF_CLKS_PER_BIT = 5208;
endpackage

// File: rtl/snn_image_rx_if.sv
// snn_image_rx_if: serial input, control and RAM write/status bundle of the image receiver
interface snn_image_rx_if #(parameter int ADDR_W = 10);
  logic uart_rx;
  logic clr;
  logic ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_data;
  logic load_done;
  logic frame_err;
  logic busy;
  modport master(input uart_rx, clr, output ram_we, ram_addr, ram_data, load_done, frame_err, busy);
  modport slave(output uart_rx, clr, input ram_we, ram_addr, ram_data, load_done, frame_err, busy);
endinterface

// File: rtl/snn_image_rx_core.sv
// uart_rx_core: synchronised 8N1 receiver; rx_valid/rx_ferr strobe in the stop-bit sample cycle
module uart_rx_core
  import snn_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr,
  input  logic       arm,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       active
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic [1:0] sync;
  logic rx_s;
  rx_state_t st;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic wait_high;
  logic tick;
  assign rx_s = sync[1];
  assign tick = cnt == FULL;
  assign rx_valid = st == STOP && tick && rx_s;
  assign rx_ferr = st == STOP && tick && !rx_s;
  assign rx_byte = sh;
  assign active = st != IDLE;
  // wait_high blocks re-arming after a framing error until the line has returned high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      wait_high <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      if (clr) st <= IDLE;
      else case (st)
        IDLE: begin
          if (rx_s) wait_high <= 1'b0;
          if (arm && !wait_high && !rx_s) begin
            st <= START;
            cnt <= '0;
          end
        end
        START:
          if (cnt == HALF) begin
            st <= rx_s ? IDLE : DATA;
            cnt <= '0;
            idx <= '0;
          end else cnt <= cnt + CW'(1);
        DATA:
          if (tick) begin
            cnt <= '0;
            sh <= {rx_s, sh[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) st <= STOP;
          end else cnt <= cnt + CW'(1);
        STOP:
          if (tick) begin
            st <= IDLE;
            wait_high <= !rx_s;
          end else cnt <= cnt + CW'(1);
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/snn_image_rx.sv
// snn_image_rx: UART image receiver unpacking each byte LSB-first into 1-bit input RAM writes
module snn_image_rx
  import snn_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_BYTES = 98,
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst_n,
  snn_image_rx_if.master bus
);
  localparam int PW = $clog2(NUM_BYTES);
  localparam logic [PW-1:0] LAST = PW'(NUM_BYTES - 1);
  rx_state_t st;
  logic [PW-1:0] ptr;
  logic [7:0] data;
  logic [2:0] j;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic rx_ferr;
  logic active;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .rx(bus.uart_rx),
    .clr(bus.clr),
    .arm(st != UNPACK),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr(rx_ferr),
    .active(active)
  );
  assign bus.busy = active | (st == UNPACK);
  // first write is issued straight from the stop-bit strobe, remaining seven from the latched byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      ptr <= '0;
      data <= '0;
      j <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_data <= 1'b0;
      bus.load_done <= 1'b0;
      bus.frame_err <= 1'b0;
    end else if (bus.clr) begin
      st <= IDLE;
      ptr <= '0;
      bus.ram_we <= 1'b0;
      bus.load_done <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      bus.frame_err <= rx_ferr;
      if (rx_valid) begin
        st <= UNPACK;
        data <= rx_byte;
        j <= '0;
        bus.ram_we <= 1'b1;
        bus.ram_addr <= ADDR_W'({ptr, 3'd0});
        bus.ram_data <= rx_byte[0];
      end else if (st == UNPACK) begin
        if (j == 3'd7) begin
          st <= IDLE;
          bus.ram_we <= 1'b0;
          ptr <= ptr == LAST ? '0 : ptr + PW'(1);
          bus.load_done <= ptr == LAST;
        end else begin
          j <= j + 3'd1;
          bus.ram_addr <= ADDR_W'({ptr, j + 3'd1});
          bus.ram_data <= data[j + 3'd1];
        end
      end
    end
  end
endmodule

// File: tb/tb_snn_image_rx.sv
// tb_snn_image_rx: directed UART frames against a RAM model of the receiver's write port
module tb_snn_image_rx;
  localparam int CPB = 16;
  localparam int NB = 98;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  snn_image_rx_if #(.ADDR_W(AW)) bus ();
  snn_image_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int ld_cnt = 0;
  int ld_ok = 0;
  int fe_cnt = 0;
  logic mem [0:1023];
  logic prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] = bus.ram_data;
      wr_cnt++;
    end
    if (bus.load_done) begin
      ld_cnt++;
      if (prev_we && prev_addr == AW'(783)) ld_ok++;
    end
    if (bus.frame_err) fe_cnt++;
    prev_we = bus.ram_we;
    prev_addr = bus.ram_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [7:0] img(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic send(input logic [7:0] b, input logic stop);
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_rx = stop;
    repeat (CPB) @(negedge clk);
    bus.uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [AW+4:0] outs;
    bus.uart_rx = 1'b1;
    bus.clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.ram_we, bus.ram_addr, bus.ram_data, bus.load_done, bus.frame_err, bus.busy};
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] e = 8'hA5;
    int w0 = wr_cnt;
    int l0 = ld_cnt;
    int bad = 0;
    send(e, 1'b1);
    for (int k = 0; k < 8; k++) if (mem[k] !== e[k]) bad++;
    tests++;
    if (wr_cnt - w0 != 8) begin
      fails++;
      $display("FAIL single_writes got %0d want 8", wr_cnt - w0);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL single_data got %0d bad bits want 0", bad);
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy got %b want 0", bus.busy);
    end
    tests++;
    if (ld_cnt != l0) begin
      fails++;
      $display("FAIL single_load_done got %0d pulses want 0", ld_cnt - l0);
    end
  endtask

  task automatic test_frame_err();
    int w0;
    int f0;
    int bad = 0;
    pulse_clr();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1);
    w0 = wr_cnt;
    f0 = fe_cnt;
    send(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    tests++;
    if (fe_cnt - f0 != 1) begin
      fails++;
      $display("FAIL ferr_pulses got %0d want 1", fe_cnt - f0);
    end
    tests++;
    if (wr_cnt != w0) begin
      fails++;
      $display("FAIL ferr_writes got %0d want 0", wr_cnt - w0);
    end
    send(8'h01, 1'b1);
    for (int k = 41; k < 48; k++) if (mem[k] !== 1'b0) bad++;
    tests++;
    if (wr_cnt - w0 != 8 || mem[40] !== 1'b1 || bad != 0) begin
      fails++;
      $display("FAIL ferr_next_byte got writes=%0d mem40=%b zero_bad=%0d want 8/1/0", wr_cnt - w0, mem[40], bad);
    end
  endtask

  task automatic test_glitch();
    int w0 = wr_cnt;
    int f0 = fe_cnt;
    int bc = 0;
    for (int k = 0; k < 3 * CPB; k++) begin
      bus.uart_rx = k < 4 ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.busy) bc++;
    end
    tests++;
    if (bc < 1 || bc > CPB / 2 + 1) begin
      fails++;
      $display("FAIL glitch_busy_cycles got %0d want 1..%0d", bc, CPB / 2 + 1);
    end
    tests++;
    if (wr_cnt != w0 || fe_cnt != f0) begin
      fails++;
      $display("FAIL glitch_side_effects got writes=%0d ferr=%0d want 0/0", wr_cnt - w0, fe_cnt - f0);
    end
  endtask

  task automatic test_clr();
    logic [7:0] e = 8'h5A;
    int w0;
    int bad = 0;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1);
    w0 = wr_cnt;
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (5 * CPB) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
      end
    join
    tests++;
    if (wr_cnt != w0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL clr_drop got writes=%0d busy=%b want 0/0", wr_cnt - w0, bus.busy);
    end
    send(e, 1'b1);
    for (int k = 0; k < 8; k++) if (mem[k] !== e[k]) bad++;
    tests++;
    if (wr_cnt - w0 != 8 || bad != 0) begin
      fails++;
      $display("FAIL clr_next_byte got writes=%0d bad=%0d want 8/0", wr_cnt - w0, bad);
    end
  endtask

  task automatic test_full_image();
    logic [7:0] b;
    logic [7:0] e = 8'hC3;
    int w0;
    int l0;
    int o0;
    int bad = 0;
    pulse_clr();
    w0 = wr_cnt;
    l0 = ld_cnt;
    o0 = ld_ok;
    for (int i = 0; i < NB; i++) send(img(i), 1'b1);
    for (int a = 0; a < NB * 8; a++) begin
      b = img(a / 8);
      if (mem[a] !== b[a % 8]) bad++;
    end
    tests++;
    if (wr_cnt - w0 != NB * 8 || bad != 0) begin
      fails++;
      $display("FAIL image_ram got writes=%0d bad=%0d want %0d/0", wr_cnt - w0, bad, NB * 8);
    end
    tests++;
    if (ld_cnt - l0 != 1 || ld_ok - o0 != 1) begin
      fails++;
      $display("FAIL image_load_done got pulses=%0d after783=%0d want 1/1", ld_cnt - l0, ld_ok - o0);
    end
    w0 = wr_cnt;
    bad = 0;
    send(e, 1'b1);
    for (int k = 0; k < 8; k++) if (mem[k] !== e[k]) bad++;
    tests++;
    if (wr_cnt - w0 != 8 || bad != 0 || ld_cnt - l0 != 1) begin
      fails++;
      $display("FAIL image_wrap got writes=%0d bad=%0d pulses=%0d want 8/0/1", wr_cnt - w0, bad, ld_cnt - l0);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW+4:0] outs;
    logic got = 1'b0;
    int w0;
    int bad = 0;
    fork
      send(8'h96, 1'b1);
      for (int k = 0; k < 400 && !got; k++) begin
        @(negedge clk);
        if (bus.ram_we && bus.ram_addr[2:0] == 3'd3) begin
          got = 1'b1;
          rst_n = 1'b0;
          #1;
          outs = {bus.ram_we, bus.ram_addr, bus.ram_data, bus.load_done, bus.frame_err, bus.busy};
          tests++;
          if (outs !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs got %h want 0", outs);
          end
        end
      end
    join
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL rst_mid_timeout got no unpack cycle 3 want one");
    end
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    tests++;
    if (wr_cnt != w0) begin
      fails++;
      $display("FAIL rst_mid_writes got %0d want 0", wr_cnt - w0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) if (mem[k] !== 1'b1) bad++;
    tests++;
    if (wr_cnt - w0 != 8 || bad != 0) begin
      fails++;
      $display("FAIL rst_mid_next_byte got writes=%0d bad=%0d want 8/0", wr_cnt - w0, bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_glitch();
    test_clr();
    test_full_image();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
